// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I front end.
// - XLEN             : architectural data/address width
// - NOP_INSTR        : canonical NOP (addi x0, x0, 0)
// - DEFAULT_RESET_PC : first fetch address after reset
// - fetch_state_e    : fetch FSM state encodings
// - word_align       : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } fetch_state_e;

  // Force an XLEN address onto a 32-bit word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_pc_next.sv
// -----------------------------------------------------------------------------
// ifu_pc_next
// Combinational next-PC logic for the fetch unit.
// Ports:
//   pc           in  n  current PC
//   pc_sel       in  1  1 = redirect to alu_target
//   alu_target   in  n  branch/jump target
//   pc_next      out n  PC to load on an advance
//   misalign_hit out 1  redirect requested with a non-word-aligned target
//   pc_plus4     out n  pc + 4, wrapping modulo 2^n
// -----------------------------------------------------------------------------
module ifu_pc_next #(
  parameter int n = 32
) (
  input  logic [n-1:0] pc,
  input  logic         pc_sel,
  input  logic [n-1:0] alu_target,
  output logic [n-1:0] pc_next,
  output logic         misalign_hit,
  output logic [n-1:0] pc_plus4
);

  // Sequential successor, target selection and alignment check.
  always_comb begin
    pc_plus4     = pc + n'(4);
    pc_next      = pc_plus4;
    misalign_hit = 1'b0;
    if (pc_sel) begin
      // Low two bits are dropped rather than trapping; the sticky flag records it.
      pc_next      = {alu_target[n-1:2], 2'b00};
      misalign_hit = (alu_target[1:0] != 2'b00);
    end else begin
      pc_next      = pc_plus4;
      misalign_hit = 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Front end of the single-issue RV32I core: owns the PC, issues one request
// at a time to instruction memory and presents instr/pc to decode.
// Ports:
//   clk, rst     in   clock, synchronous active-high reset
//   stall        in   downstream not ready; hold the presented instruction
//   PCSel        in   redirect to alu_target on an advance cycle
//   alu_target   in   redirect target from the ALU
//   imem_req     out  one-cycle request strobe
//   imem_addr    out  request address (valid with imem_req)
//   imem_rdata   in   fetched word (valid with imem_valid)
//   imem_valid   in   response strobe
//   instr, pc    out  presented instruction and its address
//   pc_plus4     out  pc + 4 (combinational from pc)
//   instr_valid  out  instr/pc meaningful
//   misalign     out  sticky misaligned-redirect flag
//   fetch_count  out  instructions consumed downstream
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int           n        = XLEN,
  parameter logic [n-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         PCSel,
  input  logic [n-1:0] alu_target,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic [n-1:0] imem_rdata,
  input  logic         imem_valid,
  output logic [n-1:0] instr,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic         instr_valid,
  output logic         misalign,
  output logic [31:0]  fetch_count
);

  fetch_state_e state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         imem_req_q, imem_req_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  logic [n-1:0] pc_next;
  logic         misalign_hit;

  ifu_pc_next #(.n(n)) u_pc_next (
    .pc           (pc_q),
    .pc_sel       (PCSel),
    .alu_target   (alu_target),
    .pc_next      (pc_next),
    .misalign_hit (misalign_hit),
    .pc_plus4     (pc_plus4)
  );

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // Any imem_valid here cannot belong to this request; ignore it.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = S_OUT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT: begin
        if (stall) begin
          // PCSel is not acted on while stalled; it is re-sampled on the advance.
          state_d = S_OUT;
        end else begin
          fetch_count_d = fetch_count_q + 32'd1;
          pc_d          = pc_next;
          misalign_d    = misalign_q | misalign_hit;
          state_d       = S_REQ;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase

    // Strobes are registered from the state being entered.
    imem_req_d    = (state_d == S_REQ);
    instr_valid_d = (state_d == S_OUT);
  end

  // State and output registers; rst overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= n'(NOP_INSTR);
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign misalign    = misalign_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Table-driven fetch sequences with a {pc, instr} scoreboard, plus hand-written
// reset-in-flight sequence. Memory is modelled by the driving task.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        PCSel;
  logic [31:0] alu_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        misalign;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  instr_fetch_unit #(.n(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .PCSel       (PCSel),
    .alu_target  (alu_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .misalign    (misalign),
    .fetch_count (fetch_count)
  );

  typedef struct {
    int          lat;       // cycles from request to response (>=1)
    int          stalls;    // stall cycles in S_OUT
    bit          spur;      // pulse imem_valid during S_REQ
    logic        pcsel;     // redirect on advance
    logic [31:0] target;    // redirect target
    logic [31:0] exp_addr;  // expected request address
    logic        exp_mis;   // expected misalign while presenting
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  sb_t         sbq[$];
  vec_t        vecs[7];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  int          req_cyc;
  int          out_cyc;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00A0_0093 + (a << 12);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_values();
    chk ("rst_pc",    pc,          32'h0000_0000);
    chk ("rst_instr", instr,       32'h0000_0013);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_req",   imem_req,    1'b0);
    chk1("rst_mis",   misalign,    1'b0);
    chk ("rst_count", fetch_count, 32'd0);
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: got imem_req=%b expected 1 within 8 cycles", imem_req);
    end
  endtask

  task automatic run_fetch(input vec_t v);
    bit  ok;
    sb_t e;
    wait_req(ok);
    if (!ok) return;
    req_cyc = cyc;
    chk ("req_addr",       imem_addr, v.exp_addr);
    chk ("req_addr_model", imem_addr, m_pc);
    chk1("valid_in_req",   instr_valid, 1'b0);
    // Optional stray response during S_REQ must be ignored.
    imem_valid = v.spur;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    for (int i = 1; i < v.lat; i++) begin
      chk1("wait_valid", instr_valid, 1'b0);
      chk1("wait_req",   imem_req,    1'b0);
      step();
    end
    imem_valid = 1'b1;
    imem_rdata = mem_word(m_pc);
    sbq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
    step();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    out_cyc = cyc;
    chk1("out_valid", instr_valid, 1'b1);
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: got 0 entries expected 1");
      return;
    end
    e = sbq.pop_front();
    chk ("out_instr",  instr,    e.instr);
    chk ("out_pc",     pc,       e.pc);
    chk ("out_pc4",    pc_plus4, e.pc + 32'd4);
    chk1("out_mis",    misalign, v.exp_mis);
    chk1("out_mis_m",  misalign, m_mis);
    // Stall with a bogus redirect pending; nothing may move.
    stall      = 1'b1;
    PCSel      = 1'b1;
    alu_target = 32'h0000_0501;
    for (int i = 0; i < v.stalls; i++) begin
      step();
      chk ("stall_instr", instr,       e.instr);
      chk ("stall_pc",    pc,          e.pc);
      chk1("stall_valid", instr_valid, 1'b1);
      chk1("stall_req",   imem_req,    1'b0);
      chk ("stall_count", fetch_count, m_cnt);
    end
    // Advance.
    stall      = 1'b0;
    PCSel      = v.pcsel;
    alu_target = v.target;
    m_cnt      = m_cnt + 32'd1;
    if (v.pcsel) begin
      m_mis = m_mis | (v.target[1:0] != 2'b00);
      m_pc  = {v.target[31:2], 2'b00};
    end else begin
      m_pc  = m_pc + 32'd4;
    end
    step();
    PCSel      = 1'b0;
    alu_target = 32'h0;
    chk ("adv_count", fetch_count, m_cnt);
    chk1("adv_mis",   misalign,    m_mis);
    chk1("adv_valid", instr_valid, 1'b0);
  endtask

  initial begin
    bit ok;
    vecs[0] = '{lat: 1, stalls: 0, spur: 1'b0, pcsel: 1'b0, target: 32'h0,         exp_addr: 32'h0000_0000, exp_mis: 1'b0};
    vecs[1] = '{lat: 1, stalls: 0, spur: 1'b0, pcsel: 1'b0, target: 32'h0,         exp_addr: 32'h0000_0004, exp_mis: 1'b0};
    vecs[2] = '{lat: 1, stalls: 0, spur: 1'b0, pcsel: 1'b0, target: 32'h0,         exp_addr: 32'h0000_0008, exp_mis: 1'b0};
    vecs[3] = '{lat: 1, stalls: 5, spur: 1'b0, pcsel: 1'b1, target: 32'h0000_0100, exp_addr: 32'h0000_000C, exp_mis: 1'b0};
    vecs[4] = '{lat: 1, stalls: 0, spur: 1'b0, pcsel: 1'b1, target: 32'h0000_0202, exp_addr: 32'h0000_0100, exp_mis: 1'b0};
    vecs[5] = '{lat: 4, stalls: 2, spur: 1'b1, pcsel: 1'b0, target: 32'h0,         exp_addr: 32'h0000_0200, exp_mis: 1'b1};
    vecs[6] = '{lat: 2, stalls: 0, spur: 1'b0, pcsel: 1'b0, target: 32'h0,         exp_addr: 32'h0000_0204, exp_mis: 1'b1};

    rst        = 1'b1;
    stall      = 1'b0;
    PCSel      = 1'b0;
    alu_target = 32'h0;
    imem_rdata = 32'h0;
    imem_valid = 1'b0;
    cyc        = 0;
    step();
    step();
    cyc = 0;
    check_reset_values();
    rst   = 1'b0;
    m_pc  = 32'h0;
    m_cnt = 32'd0;
    m_mis = 1'b0;

    for (int k = 0; k < 7; k++) begin
      run_fetch(vecs[k]);
      if (k == 0) begin
        chk("first_req_cycle", req_cyc, 32'd1);
        chk("first_out_cycle", out_cyc, 32'd3);
      end
      if (k == 3) begin
        chk("count_after_4", fetch_count, 32'd4);
      end
    end

    // Reset while a request is in flight.
    wait_req(ok);
    if (ok) begin
      chk("pre_rst_addr", imem_addr, m_pc);
      step();
      chk1("pre_rst_wait", imem_req, 1'b0);
      rst = 1'b1;
      step();
      cyc = 0;
      check_reset_values();
      rst   = 1'b0;
      m_pc  = 32'h0;
      m_cnt = 32'd0;
      m_mis = 1'b0;
      run_fetch('{lat: 1, stalls: 0, spur: 1'b0, pcsel: 1'b0, target: 32'h0,
                  exp_addr: 32'h0000_0000, exp_mis: 1'b0});
      chk("restart_req_cycle", req_cyc, 32'd1);
      chk("restart_out_cycle", out_cyc, 32'd3);
    end

    chk("sb_leftover", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
